// File: rtl/bcd_display_scheduler_pkg.sv
// ==== bcd_display_scheduler_pkg : FSM states, segment constants, source names, decoder
// ==== Rev 1.0
`default_nettype none

package bcd_display_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CONV  = 2'd1,
    ST_LATCH = 2'd2
  } state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  localparam logic [1:0] SRC_CREDIT = 2'd0;
  localparam logic [1:0] SRC_PRICE  = 2'd1;
  localparam logic [1:0] SRC_CHANGE = 2'd2;

  // Active-low {g,f,e,d,c,b,a}; non-decimal codes render as a dash
  function automatic logic [6:0] seg7_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = SEG_DASH;
    endcase
    return s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_display_scheduler_seg7_scan.sv
// ==== bcd_display_scheduler_seg7_scan : digit scan counter, leading-zero blanking, decode
// ==== Rev 1.0
`default_nettype none

module bcd_display_scheduler_seg7_scan
  import bcd_display_scheduler_pkg::*;
#(
  parameter int SCAN_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] digits,
  output logic [3:0]  an,
  output logic [6:0]  seg
);

  localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;

  logic [3:0] thou, hund, tens, ones;
  logic       blank_thou, blank_hund, blank_tens;
  logic [3:0] cur_digit;
  logic       cur_blank;

  assign {thou, hund, tens, ones} = digits;
  assign blank_thou = (thou == 4'd0);
  assign blank_hund = blank_thou && (hund == 4'd0);
  assign blank_tens = blank_hund && (tens == 4'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      idx_q <= 2'd0;
      an_q  <= 4'b1111;
      seg_q <= SEG_BLANK;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    idx_d = idx_q;
    if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end
  end

  // an/seg are registered from the current idx so they move together
  always_comb begin
    cur_digit = ones;
    cur_blank = 1'b0;
    case (idx_q)
      2'd0: begin cur_digit = ones; cur_blank = 1'b0;       end
      2'd1: begin cur_digit = tens; cur_blank = blank_tens; end
      2'd2: begin cur_digit = hund; cur_blank = blank_hund; end
      default: begin cur_digit = thou; cur_blank = blank_thou; end
    endcase
    an_d  = ~(4'b0001 << idx_q);
    seg_d = cur_blank ? SEG_BLANK : seg7_decode(cur_digit);
  end

  assign an  = an_q;
  assign seg = seg_q;

endmodule

`default_nettype wire

// File: rtl/bcd_display_scheduler.sv
// ==== bcd_display_scheduler : round-robin sharing of one BCD converter, latched 4-digit scan
// ==== Rev 1.0
`default_nettype none

module bcd_display_scheduler
  import bcd_display_scheduler_pkg::*;
#(
  parameter int NREQ     = 3,
  parameter int BIN_W    = 11,
  parameter int CONV_LAT = 1,
  parameter int SCAN_DIV = 100000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*BIN_W-1:0] val,
  output logic [NREQ-1:0]       ack,
  output logic                  busy,
  output logic [1:0]            shown_src,
  output logic [BIN_W-1:0]      conv_bin,
  input  logic [3:0]            conv_thou,
  input  logic [3:0]            conv_hund,
  input  logic [3:0]            conv_tens,
  input  logic [3:0]            conv_ones,
  output logic [3:0]            an,
  output logic [6:0]            seg
);

  localparam int LAT_W = (CONV_LAT > 2) ? $clog2(CONV_LAT) : 1;

  state_e             state_q, state_d;
  logic [1:0]         ptr_q, ptr_d;
  logic [1:0]         grant_q, grant_d;
  logic [LAT_W-1:0]   wait_q, wait_d;
  logic [BIN_W-1:0]   conv_bin_q, conv_bin_d;
  logic [15:0]        digits_q, digits_d;
  logic [1:0]         shown_src_q, shown_src_d;

  logic               any_req;
  logic [1:0]         pick;

  function automatic logic [1:0] rr_index(input logic [1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NREQ) s = s - NREQ;
    return s[1:0];
  endfunction

  // Scan downward so the lowest rotation offset from ptr wins
  always_comb begin
    any_req = 1'b0;
    pick    = ptr_q;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[rr_index(ptr_q, k)]) begin
        any_req = 1'b1;
        pick    = rr_index(ptr_q, k);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= 2'd0;
      grant_q     <= 2'd0;
      wait_q      <= '0;
      conv_bin_q  <= '0;
      digits_q    <= 16'h0000;
      shown_src_q <= 2'd0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      wait_q      <= wait_d;
      conv_bin_q  <= conv_bin_d;
      digits_q    <= digits_d;
      shown_src_q <= shown_src_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    wait_d      = wait_q;
    conv_bin_d  = conv_bin_q;
    digits_d    = digits_q;
    shown_src_d = shown_src_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          grant_d    = pick;
          conv_bin_d = val[int'(pick)*BIN_W +: BIN_W];
          wait_d     = '0;
          state_d    = ST_CONV;
        end
      end
      ST_CONV: begin
        wait_d = wait_q + LAT_W'(1);
        if (wait_q == LAT_W'(CONV_LAT - 1)) state_d = ST_LATCH;
      end
      ST_LATCH: begin
        digits_d    = {conv_thou, conv_hund, conv_tens, conv_ones};
        shown_src_d = grant_q;
        ptr_d       = rr_index(grant_q, 1);
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ack  = '0;
    busy = (state_q != ST_IDLE);
    if (state_q == ST_LATCH) ack[grant_q] = 1'b1;
  end

  assign conv_bin  = conv_bin_q;
  assign shown_src = shown_src_q;

  bcd_display_scheduler_seg7_scan #(
    .SCAN_DIV(SCAN_DIV)
  ) u_seg7_scan (
    .clk    (clk),
    .rst    (rst),
    .digits (digits_q),
    .an     (an),
    .seg    (seg)
  );

endmodule

`default_nettype wire

// File: tb/tb_bcd_display_scheduler.sv
// ==== tb_bcd_display_scheduler : directed checks of arbitration, latency, scan and blanking
// ==== Rev 1.0
`default_nettype none

module tb_bcd_display_scheduler;

  localparam int NREQ     = 3;
  localparam int BIN_W    = 11;
  localparam int CONV_LAT = 1;
  localparam int SCAN_DIV = 4;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*BIN_W-1:0] val = '0;
  logic [NREQ-1:0]       ack;
  logic                  busy;
  logic [1:0]            shown_src;
  logic [BIN_W-1:0]      conv_bin;
  logic [3:0]            conv_thou, conv_hund, conv_tens, conv_ones;
  logic [3:0]            an;
  logic [6:0]            seg;
  logic                  stub = 1'b0;

  int total = 0;
  int bad   = 0;
  int model_v;

  always #5 clk = ~clk;

  // Behavioural binary_to_bcd; stub forces an illegal ones code
  always_comb begin
    model_v   = int'(conv_bin);
    conv_thou = 4'((model_v / 1000) % 10);
    conv_hund = 4'((model_v / 100) % 10);
    conv_tens = 4'((model_v / 10) % 10);
    conv_ones = stub ? 4'hC : 4'(model_v % 10);
  end

  bcd_display_scheduler #(
    .NREQ(NREQ), .BIN_W(BIN_W), .CONV_LAT(CONV_LAT), .SCAN_DIV(SCAN_DIV)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .val(val), .ack(ack), .busy(busy),
    .shown_src(shown_src), .conv_bin(conv_bin),
    .conv_thou(conv_thou), .conv_hund(conv_hund), .conv_tens(conv_tens), .conv_ones(conv_ones),
    .an(an), .seg(seg)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_an(input logic [3:0] pat, input logic [6:0] exp_seg, input string tag);
    int n;
    n = 0;
    while (an !== pat && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_an"}, 32'(an), 32'(pat));
    chk(tag, 32'(seg), 32'(exp_seg));
  endtask

  task automatic check_display(input logic [6:0] s_thou, input logic [6:0] s_hund,
                               input logic [6:0] s_tens, input logic [6:0] s_ones,
                               input string tag);
    tick();
    wait_an(4'b1110, s_ones, {tag, "_ones"});
    wait_an(4'b1101, s_tens, {tag, "_tens"});
    wait_an(4'b1011, s_hund, {tag, "_hund"});
    wait_an(4'b0111, s_thou, {tag, "_thou"});
  endtask

  task automatic do_single(input int src, input int value, input string tag);
    val[src*BIN_W +: BIN_W] = BIN_W'(value);
    req = 3'(1 << src);
    tick();
    chk({tag, "_conv_ack"}, 32'(ack), 32'h0);
    chk({tag, "_conv_busy"}, 32'(busy), 32'h1);
    chk({tag, "_conv_bin"}, 32'(conv_bin), 32'(value));
    tick();
    chk({tag, "_latch_ack"}, 32'(ack), 32'(1 << src));
    req = '0;
    tick();
    chk({tag, "_idle_ack"}, 32'(ack), 32'h0);
    chk({tag, "_idle_busy"}, 32'(busy), 32'h0);
    chk({tag, "_shown_src"}, 32'(shown_src), 32'(src));
  endtask

  logic [3:0] an_seq [4];
  int         rr_ord [4];

  initial begin
    an_seq = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    rr_ord = '{0, 1, 2, 0};

    // Reset state
    tick();
    tick();
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_shown", 32'(shown_src), 32'h0);
    chk("rst_conv_bin", 32'(conv_bin), 32'h0);
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_seg", 32'(seg), 32'h7F);
    rst = 1'b0;

    // Scan order, four cycles per digit, then wrap
    for (int i = 0; i < 17; i++) begin
      tick();
      chk("scan_an", 32'(an), 32'(an_seq[(i / 4) % 4]));
    end

    // 1234 on source 0
    do_single(0, 1234, "v1234");
    check_display(7'h79, 7'h24, 7'h30, 7'h19, "d1234");

    // All three requesting: strict rotation from ptr=0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    val = {11'd700, 11'd60, 11'd5};
    req = 3'b111;
    for (int t = 0; t < 11; t++) begin
      tick();
      if (t % 3 == 1) chk("rr_ack", 32'(ack), 32'(1 << rr_ord[t / 3]));
      else            chk("rr_ack_quiet", 32'(ack), 32'h0);
      if (t % 3 == 2) chk("rr_shown", 32'(shown_src), 32'(rr_ord[t / 3]));
      if (t == 10) req = '0;
    end
    tick();
    chk("rr_final_shown", 32'(shown_src), 32'h0);
    check_display(7'h7F, 7'h7F, 7'h7F, 7'h12, "d5");

    do_single(1, 60, "v60");
    check_display(7'h7F, 7'h7F, 7'h02, 7'h40, "d60");
    do_single(2, 700, "v700");
    check_display(7'h7F, 7'h78, 7'h40, 7'h40, "d700");

    // Boundaries: zero and full scale
    do_single(0, 0, "v0");
    check_display(7'h7F, 7'h7F, 7'h7F, 7'h40, "d0");
    do_single(0, 2047, "v2047");
    check_display(7'h24, 7'h40, 7'h19, 7'h78, "d2047");

    // req dropped during CONV still completes
    val[0 +: BIN_W] = 11'd321;
    req = 3'b001;
    tick();
    req = '0;
    chk("drop_conv_busy", 32'(busy), 32'h1);
    tick();
    chk("drop_ack", 32'(ack), 32'h1);
    tick();
    chk("drop_idle_busy", 32'(busy), 32'h0);
    tick();
    chk("drop_no_regrant", 32'(busy), 32'h0);
    chk("drop_no_ack", 32'(ack), 32'h0);
    check_display(7'h7F, 7'h30, 7'h24, 7'h79, "d321");

    // Reset mid-conversion aborts and restores ptr=0
    val[0 +: BIN_W] = 11'd999;
    req = 3'b001;
    tick();
    chk("abort_conv_busy", 32'(busy), 32'h1);
    rst = 1'b1;
    req = '0;
    tick();
    chk("abort_ack", 32'(ack), 32'h0);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_an", 32'(an), 32'hF);
    chk("abort_seg", 32'(seg), 32'h7F);
    chk("abort_shown", 32'(shown_src), 32'h0);
    rst = 1'b0;
    tick();
    chk("abort_after_ack", 32'(ack), 32'h0);
    check_display(7'h7F, 7'h7F, 7'h7F, 7'h40, "dabort");
    val = {11'd0, 11'd222, 11'd111};
    req = 3'b011;
    tick();
    chk("fresh_conv_bin", 32'(conv_bin), 32'd111);
    tick();
    chk("fresh_ack", 32'(ack), 32'h1);
    req = '0;
    tick();

    // Illegal ones code renders as a dash
    stub = 1'b1;
    do_single(2, 5, "vstub");
    stub = 1'b0;
    check_display(7'h7F, 7'h7F, 7'h7F, 7'h3F, "dstub");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
